cic_ctrl: RTL and testbench

Run-control sequencer for the CIC decimator.
- Clears the CIC, then paces input samples into it at a programmable strobe interval from an upstream valid/ready source.
- Suppresses the CIC's start-up transient outputs, drains the pipeline after the last sample, then reports completion.
- Sits between the sample source and the CIC instance; is the only driver of the CIC's clear, valid and data inputs.

---
 rtl/cic_ctrl_pkg.sv | 11 +
 rtl/cic_ctrl_tick.sv | 21 ++
 rtl/cic_ctrl.sv | 139 +++++++++++++
 tb/tb_cic_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_ctrl_pkg.sv
// cic_ctrl_pkg: shared state encoding and default sizes for the CIC run-control sequencer
package cic_ctrl_pkg;
  localparam int WIN_DEF       = 16;
  localparam int WOUT_DEF      = 16;
  localparam int DIV_W_DEF     = 16;
  localparam int CNT_W_DEF     = 16;
  localparam int CLR_CYC_DEF   = 8;
  localparam int DRAIN_CYC_DEF = 64;
  localparam int PH_W          = 16;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/cic_ctrl_tick.sv
// cic_ctrl_tick: loadable down-counter producing the input slot strobe
module cic_ctrl_tick
  import cic_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] reload,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = en && cnt == '0;
  // park at zero while cleared so the first enabled cycle strobes, then reload on every strobe
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? reload : cnt - 1'b1;
endmodule

// File: rtl/cic_ctrl.sv
// cic_ctrl: clears, paces, drains and reports completion for a CIC decimator run
// Optional: define CIC_CTRL_HOLD_LAST_EN to repeat the last accepted sample on underrun instead of inserting 0.
module cic_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int Win       = WIN_DEF,
  parameter int Wout      = WOUT_DEF,
  parameter int DIV_W     = DIV_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int CLR_CYC   = CLR_CYC_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] cfg_interval,
  input  logic [CNT_W-1:0] cfg_nsamples,
  input  logic [7:0]       cfg_discard,
  input  logic [Win-1:0]   src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             cic_clr,
  output logic             cic_val_in,
  output logic [Win-1:0]   cic_data,
  input  logic             cic_val_out,
  input  logic [Wout-1:0]  cic_data_out,
  output logic             o_valid,
  output logic [Wout-1:0]  o_data,
  output logic             busy,
  output logic             done,
  output logic             underrun,
  output logic [CNT_W-1:0] in_cnt,
  output logic [CNT_W-1:0] out_cnt
);
  state_t state, nxt;
  logic [DIV_W-1:0] ival_m1;
  logic [CNT_W-1:0] nsamp;
  logic [7:0] discard;
  logic [PH_W-1:0] ph;
  logic slot, fire, last_slot, ph_end, go, out_act;
  logic [Win-1:0] fill;

  assign go        = state == IDLE && start;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign cic_clr   = state == IDLE || state == CLEAR;
  assign out_act   = state == RUN || state == DRAIN;
  assign fire      = slot && !stop;
  assign src_ready = fire;
  assign last_slot = fire && nsamp != '0 && in_cnt == nsamp - 1'b1;
  assign ph_end    = state == CLEAR ? ph == PH_W'(CLR_CYC - 1) : ph == PH_W'(DRAIN_CYC - 1);

  cic_ctrl_tick #(.DIV_W(DIV_W)) u_tick (
    .clk(clk),
    .rst(rst),
    .en(state == RUN),
    .clr(state != RUN),
    .reload(ival_m1),
    .tick(slot)
  );

  // next-state selection; a stop coinciding with a slot suppresses that slot and drains
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? CLEAR : IDLE;
      CLEAR:   nxt = stop ? IDLE : ph_end ? RUN : CLEAR;
      RUN:     nxt = stop || last_slot ? DRAIN : RUN;
      DRAIN:   nxt = ph_end ? DONE : DRAIN;
      default: nxt = IDLE;
    endcase
  end

  // state register plus a phase counter that restarts on every state change
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      ph    <= '0;
    end else begin
      state <= nxt;
      ph    <= nxt != state ? '0 : ph + 1'b1;
    end

  // run configuration latch and the input strobe path into the CIC
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ival_m1    <= '0;
      nsamp      <= '0;
      discard    <= '0;
      in_cnt     <= '0;
      underrun   <= 1'b0;
      cic_val_in <= 1'b0;
      cic_data   <= '0;
    end else begin
      cic_val_in <= fire;
      if (go) begin
        ival_m1  <= cfg_interval == '0 ? '0 : cfg_interval - 1'b1;
        nsamp    <= cfg_nsamples;
        discard  <= cfg_discard;
        in_cnt   <= '0;
        underrun <= 1'b0;
      end else if (fire) begin
        cic_data <= src_valid ? src_data : fill;
        in_cnt   <= &in_cnt ? in_cnt : in_cnt + 1'b1;
        underrun <= underrun | !src_valid;
      end
    end

  // output forwarding: count every CIC output, drop the start-up transient ones
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_cnt <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= 1'b0;
      if (go) out_cnt <= '0;
      else if (out_act && cic_val_out) begin
        out_cnt <= &out_cnt ? out_cnt : out_cnt + 1'b1;
        if (out_cnt >= CNT_W'(discard)) begin
          o_valid <= 1'b1;
          o_data  <= cic_data_out;
        end
      end
    end

`ifdef CIC_CTRL_HOLD_LAST_EN
  logic [Win-1:0] last_smp;
  // remember the most recent accepted sample of this run for underrun fill
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_smp <= '0;
    else if (go) last_smp <= '0;
    else if (fire && src_valid) last_smp <= src_data;
  assign fill = last_smp;
`else
  assign fill = '0;
`endif
endmodule

// File: tb/tb_cic_ctrl.sv
// tb_cic_ctrl: directed self-checking bench for the CIC run-control sequencer
module tb_cic_ctrl;
  import cic_ctrl_pkg::*;
`ifdef CIC_CTRL_HOLD_LAST_EN
  localparam logic [15:0] FILL3 = 16'd2;
`else
  localparam logic [15:0] FILL3 = 16'd0;
`endif
  localparam int FIRST_LAT = CLR_CYC_DEF + 1;
  localparam int DONE_LAT  = DRAIN_CYC_DEF + 1;

  logic clk = 1'b0;
  logic rst, start, stop, src_valid, src_ready, cic_clr, cic_val_in, cic_val_out;
  logic o_valid, busy, done, underrun;
  logic [15:0] cfg_interval, cfg_nsamples, src_data, cic_data, cic_data_out, o_data, in_cnt, out_cnt;
  logic [7:0] cfg_discard;
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int t_start;
  int drop_slot;
  int rdy_q[$];
  int val_q[$];
  int done_q[$];
  logic [15:0] vdat_q[$];

  cic_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_interval(cfg_interval), .cfg_nsamples(cfg_nsamples), .cfg_discard(cfg_discard),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .cic_clr(cic_clr), .cic_val_in(cic_val_in), .cic_data(cic_data),
    .cic_val_out(cic_val_out), .cic_data_out(cic_data_out),
    .o_valid(o_valid), .o_data(o_data), .busy(busy), .done(done),
    .underrun(underrun), .in_cnt(in_cnt), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (src_ready) rdy_q.push_back(cyc);
    if (cic_val_in) begin
      val_q.push_back(cyc);
      vdat_q.push_back(cic_data);
    end
    if (done) done_q.push_back(cyc);
  end

  initial begin
    logic s, v, st;
    int slot_no, used;
    slot_no = 0;
    used = 0;
    src_valid = 1'b1;
    src_data = 16'd1;
    forever begin
      @(negedge clk);
      s = src_ready;
      v = src_valid;
      st = start;
      @(posedge clk);
      #1;
      if (st) begin
        slot_no = 0;
        used = 0;
      end else if (s) begin
        slot_no++;
        if (v) used++;
      end
      src_data = 16'(used + 1);
      src_valid = !(drop_slot != 0 && slot_no + 1 == drop_slot);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pedge;
    @(posedge clk);
    #1;
  endtask

  task automatic nedge;
    @(negedge clk);
    #1;
  endtask

  task automatic run(input logic [15:0] iv, input logic [15:0] ns, input logic [7:0] dis);
    pedge;
    cfg_interval = iv;
    cfg_nsamples = ns;
    cfg_discard = dis;
    start = 1'b1;
    t_start = cyc;
    pedge;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin
      nedge;
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic wait_slots(input int base, input int n, input int budget, input string tag);
    int k = 0;
    while (rdy_q.size() - base < n && k < budget) begin
      nedge;
      k++;
    end
    check(tag, rdy_q.size() - base, n);
  endtask

  initial begin
    int r0, v0, d0, bad;
    rst = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    cfg_interval = '0;
    cfg_nsamples = '0;
    cfg_discard = '0;
    cic_val_out = 1'b0;
    cic_data_out = '0;
    drop_slot = 0;
    repeat (3) nedge;
    check("rst_cic_clr", cic_clr, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_val_in", cic_val_in, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_in_cnt", in_cnt, 0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_underrun", underrun, 0);
    check("rst_cic_data", cic_data, 0);
    pedge;
    rst = 1'b1;
    pedge;
    stop = 1'b1;
    pedge;
    stop = 1'b0;
    check("idle_stop_ignored", busy, 0);

    // 1: long interval, spacing and drain latency
    r0 = rdy_q.size(); v0 = val_q.size(); d0 = done_q.size();
    run(16'd2000, 16'd12, 8'd0);
    wait_done(30000, "t1_done");
    check("t1_slots", rdy_q.size() - r0, 12);
    check("t1_first_slot", rdy_q[r0] - t_start, FIRST_LAT);
    bad = 0;
    for (int i = r0 + 1; i < rdy_q.size(); i++) if (rdy_q[i] - rdy_q[i-1] != 2000) bad++;
    check("t1_gaps", bad, 0);
    check("t1_vals", val_q.size() - v0, 12);
    bad = 0;
    for (int i = 0; i < val_q.size() - v0 && i < rdy_q.size() - r0; i++) begin
      if (val_q[v0+i] != rdy_q[r0+i] + 1) bad++;
      if (vdat_q[v0+i] != 16'(i + 1)) bad++;
    end
    check("t1_val_pairing", bad, 0);
    check("t1_in_cnt", in_cnt, 12);
    check("t1_underrun", underrun, 0);
    check("t1_drain_lat", done_q[d0] - rdy_q[rdy_q.size()-1], DONE_LAT);

    // 2: interval 1, back-to-back strobes
    v0 = val_q.size();
    run(16'd1, 16'd8, 8'd0);
    wait_done(200, "t2_done");
    check("t2_busy_at_done", busy, 1);
    nedge;
    check("t2_busy_after", busy, 0);
    check("t2_clr_after", cic_clr, 1);
    check("t2_vals", val_q.size() - v0, 8);
    check("t2_span", val_q[val_q.size()-1] - val_q[v0], 7);
    bad = 0;
    for (int i = 0; i < val_q.size() - v0; i++) if (vdat_q[v0+i] != 16'(i + 1)) bad++;
    check("t2_data", bad, 0);

    // 3: underrun on slot 3
    v0 = val_q.size();
    drop_slot = 3;
    run(16'd4, 16'd5, 8'd0);
    wait_done(300, "t3_done");
    drop_slot = 0;
    check("t3_underrun", underrun, 1);
    check("t3_in_cnt", in_cnt, 5);
    check("t3_vals", val_q.size() - v0, 5);
    check("t3_strobe2", vdat_q[v0+1], 2);
    check("t3_strobe3", vdat_q[v0+2], FILL3);
    check("t3_strobe4", vdat_q[v0+3], 3);

    // 4: discard the first three CIC outputs
    r0 = rdy_q.size();
    run(16'd4, 16'd4, 8'd3);
    wait_slots(r0, 1, 50, "t4_first_slot");
    check("t4_underrun_cleared", underrun, 0);
    for (int i = 0; i < 6; i++) begin
      pedge;
      cic_val_out = 1'b1;
      cic_data_out = 16'(10 + i);
      pedge;
      cic_val_out = 1'b0;
      check("t4_o_valid", o_valid, i >= 3);
      if (i >= 3) check("t4_o_data", o_data, 10 + i);
    end
    wait_done(300, "t4_done");
    check("t4_out_cnt", out_cnt, 6);
    pedge;
    cic_val_out = 1'b1;
    cic_data_out = 16'd99;
    pedge;
    cic_val_out = 1'b0;
    check("t4_idle_o_valid", o_valid, 0);
    check("t4_idle_out_cnt", out_cnt, 6);

    // 5: continuous mode, stop on a slot, start during drain
    r0 = rdy_q.size(); d0 = done_q.size();
    run(16'd10, 16'd0, 8'd0);
    wait_slots(r0, 25, 400, "t5_25_slots");
    repeat (10) pedge;
    stop = 1'b1;
    #1;
    check("t5_stop_slot", src_ready, 0);
    pedge;
    stop = 1'b0;
    check("t5_busy_drain", busy, 1);
    check("t5_no_strobe", cic_val_in, 0);
    check("t5_in_cnt", in_cnt, 25);
    cfg_nsamples = 16'd7;
    start = 1'b1;
    pedge;
    start = 1'b0;
    wait_done(200, "t5_done");
    check("t5_in_cnt_kept", in_cnt, 25);
    check("t5_slots", rdy_q.size() - r0, 25);
    nedge;
    check("t5_idle", busy, 0);
    check("t5_one_done", done_q.size() - d0, 1);

    // 6: asynchronous reset mid-run, then a fresh run
    r0 = rdy_q.size();
    run(16'd3, 16'd20, 8'd0);
    wait_slots(r0, 3, 100, "t6_slots_before");
    pedge;
    d0 = done_q.size();
    rst = 1'b0;
    #1;
    check("t6_clr", cic_clr, 1);
    check("t6_busy", busy, 0);
    check("t6_in_cnt", in_cnt, 0);
    check("t6_src_ready", src_ready, 0);
    check("t6_val_in", cic_val_in, 0);
    repeat (3) pedge;
    rst = 1'b1;
    pedge;
    check("t6_no_done", done_q.size() - d0, 0);
    r0 = rdy_q.size();
    run(16'd2, 16'd3, 8'd0);
    wait_done(200, "t6_fresh_done");
    check("t6_fresh_in_cnt", in_cnt, 3);
    check("t6_fresh_slots", rdy_q.size() - r0, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
